// File: rtl/evt_spike_encoder.sv
// Spike-vector to event-stream encoder with shadow batch capture.
// Optional overflow counter: define SNE_SPIKE_ENC_OVF_CNT_EN.
package evt_spike_encoder_pkg;
  typedef logic [31:0] timestamp_t;
endpackage

module evt_spike_encoder
  import evt_spike_encoder_pkg::*;
#(
  parameter int DP_GROUP  = 16,
  parameter int ENGINE_ID = 0,
  parameter int NID_WIDTH = 16
) (
  input  logic                 engine_clk_i,
  input  logic                 engine_rst_i,
  input  logic [DP_GROUP-1:0]  spike_i,
  input  timestamp_t           global_time_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [NID_WIDTH-1:0] evt_nid_o,
  output timestamp_t           evt_time_o,
  output logic                 busy_o,
  output logic                 overflow_o,
  output logic [15:0]          overflow_cnt_o
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  localparam logic [31:0] NID_BASE = 32'(ENGINE_ID * DP_GROUP);
  localparam logic [DP_GROUP-1:0] ONE = DP_GROUP'(1);

  state_t state_q, state_d;

  logic [DP_GROUP-1:0] active_q, active_d;
  timestamp_t          active_time_q, active_time_d;
  logic [DP_GROUP-1:0] shadow_q, shadow_d;
  timestamp_t          shadow_time_q, shadow_time_d;

  logic                 valid_q, valid_d;
  logic [NID_WIDTH-1:0] nid_q, nid_d;
  timestamp_t           time_q, time_d;
  logic                 ovf_q, ovf_d;

  logic                hs;
  logic [DP_GROUP-1:0] cur;
  logic [DP_GROUP-1:0] remain;
  logic [DP_GROUP-1:0] merged;
  logic [DP_GROUP-1:0] collide;

  function automatic logic [DP_GROUP-1:0] lsb_onehot(
    input logic [DP_GROUP-1:0] v
  );
    return v & (~v + ONE);
  endfunction

  function automatic logic [31:0] lsb_idx(
    input logic [DP_GROUP-1:0] v
  );
    logic [31:0] r;
    r = '0;
    for (int i = DP_GROUP - 1; i >= 0; i--) begin
      if (v[i]) r = 32'(i);
    end
    return r;
  endfunction

  // Next-state: batch capture, drain, shadow merge and swap.
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    active_time_d = active_time_q;
    shadow_d      = shadow_q;
    shadow_time_d = shadow_time_q;
    collide       = '0;
    hs            = valid_q & evt_ready_i;
    cur           = hs ? lsb_onehot(active_q) : '0;
    remain        = active_q & ~cur;
    merged        = shadow_q | spike_i;
    unique case (state_q)
      IDLE: begin
        if (|spike_i) begin
          active_d      = spike_i;
          active_time_d = global_time_i;
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && (remain == '0)) begin
          if (|merged) begin
            active_d      = merged;
            active_time_d = (|shadow_q) ? shadow_time_q
                                        : global_time_i;
            shadow_d      = '0;
          end else begin
            active_d = '0;
            state_d  = IDLE;
          end
        end else begin
          active_d = remain;
          collide  = spike_i & shadow_q;
          shadow_d = merged;
          if ((shadow_q == '0) && (|spike_i)) begin
            shadow_time_d = global_time_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = |active_d;
    nid_d   = NID_WIDTH'(NID_BASE + lsb_idx(active_d));
    time_d  = active_time_d;
    ovf_d   = |collide;
  end

  // State, batch and output registers.
  always_ff @(posedge engine_clk_i) begin
    if (engine_rst_i) begin
      state_q       <= IDLE;
      active_q      <= '0;
      active_time_q <= '0;
      shadow_q      <= '0;
      shadow_time_q <= '0;
      valid_q       <= 1'b0;
      nid_q         <= '0;
      time_q        <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      active_time_q <= active_time_d;
      shadow_q      <= shadow_d;
      shadow_time_q <= shadow_time_d;
      valid_q       <= valid_d;
      nid_q         <= nid_d;
      time_q        <= time_d;
      ovf_q         <= ovf_d;
    end
  end

`ifdef SNE_SPIKE_ENC_OVF_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_sum;

  // Saturating count of spikes lost to shadow collisions.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 17'($countones(collide));
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // Overflow counter register.
  always_ff @(posedge engine_clk_i) begin
    if (engine_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign overflow_cnt_o = cnt_q;
`else
  assign overflow_cnt_o = 16'h0000;
`endif

  assign evt_valid_o = valid_q;
  assign evt_nid_o   = nid_q;
  assign evt_time_o  = time_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q == DRAIN) | (shadow_q != '0);

endmodule

// File: tb/tb_evt_spike_encoder.sv
// Self-checking bench for evt_spike_encoder.
// Two instances (ENGINE_ID 0 and 2) share stimulus.
module tb_evt_spike_encoder;
  import evt_spike_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] spike = '0;
  timestamp_t  gtime = '0;
  logic        ready = 1'b0;

  logic        v0, v2, b0, b2, o0, o2;
  logic [15:0] n0, n2, c0, c2;
  timestamp_t  t0, t2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  evt_spike_encoder #(.DP_GROUP(16), .ENGINE_ID(0), .NID_WIDTH(16)) dut0 (
    .engine_clk_i(clk), .engine_rst_i(rst_i), .spike_i(spike),
    .global_time_i(gtime), .evt_valid_o(v0), .evt_ready_i(ready),
    .evt_nid_o(n0), .evt_time_o(t0), .busy_o(b0),
    .overflow_o(o0), .overflow_cnt_o(c0)
  );

  evt_spike_encoder #(.DP_GROUP(16), .ENGINE_ID(2), .NID_WIDTH(16)) dut2 (
    .engine_clk_i(clk), .engine_rst_i(rst_i), .spike_i(spike),
    .global_time_i(gtime), .evt_valid_o(v2), .evt_ready_i(ready),
    .evt_nid_o(n2), .evt_time_o(t2), .busy_o(b2),
    .overflow_o(o2), .overflow_cnt_o(c2)
  );

  // Reference model: pending ids of the current batch in emit order,
  // a set of deferred spikes, and their capture times.
  int          m_act[$];
  logic [15:0] m_shadow = '0;
  timestamp_t  m_at = '0;
  timestamp_t  m_st = '0;
  logic        m_ovf = 1'b0;
  int          m_cnt = 0;

  function automatic void load_batch(input logic [15:0] bits);
    m_act = {};
    for (int i = 0; i < 16; i++) begin
      if (bits[i]) m_act.push_back(i);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic model_step(input logic [15:0] sp, input logic rdy,
                            input timestamp_t t, input logic rst);
    logic        was_valid;
    logic [15:0] lost;
    lost = '0;
    if (rst) begin
      m_act = {};
      m_shadow = '0;
      m_cnt = 0;
      m_ovf = 1'b0;
      return;
    end
    was_valid = (m_act.size() > 0);
    if (!was_valid) begin
      if (sp != 0) begin
        load_batch(sp);
        m_at = t;
      end
    end else begin
      if (rdy) void'(m_act.pop_front());
      if (m_act.size() == 0) begin
        if ((m_shadow | sp) != 0) begin
          load_batch(m_shadow | sp);
          m_at = (m_shadow != 0) ? m_st : t;
          m_shadow = '0;
        end
      end else begin
        lost = sp & m_shadow;
        if (m_shadow == 0 && sp != 0) m_st = t;
        m_shadow = m_shadow | sp;
      end
    end
    m_ovf = (lost != 0);
`ifdef SNE_SPIKE_ENC_OVF_CNT_EN
    m_cnt = m_cnt + $countones(lost);
    if (m_cnt > 65535) m_cnt = 65535;
`else
    m_cnt = 0;
`endif
  endtask

  task automatic compare_model();
    logic mv;
    mv = (m_act.size() > 0);
    chk("valid0", 32'(v0), 32'(mv));
    chk("valid2", 32'(v2), 32'(mv));
    chk("busy0", 32'(b0), 32'(mv || m_shadow != 0));
    chk("busy2", 32'(b2), 32'(mv || m_shadow != 0));
    chk("ovf0", 32'(o0), 32'(m_ovf));
    chk("ovf2", 32'(o2), 32'(m_ovf));
    chk("cnt0", 32'(c0), 32'(m_cnt));
    chk("cnt2", 32'(c2), 32'(m_cnt));
    if (mv) begin
      chk("nid0", 32'(n0), 32'(m_act[0]));
      chk("nid2", 32'(n2), 32'(32 + m_act[0]));
      chk("time0", t0, m_at);
      chk("time2", t2, m_at);
    end
  endtask

  task automatic cycle(input logic [15:0] sp, input logic rdy,
                       input timestamp_t t, input logic rst);
    spike = sp;
    ready = rdy;
    gtime = t;
    rst_i = rst;
    @(posedge clk);
    model_step(sp, rdy, t, rst);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [15:0] sp;
    logic        rdy;
    timestamp_t  t;
    logic        rst;
    logic        ev;
    logic [15:0] enid;
    timestamp_t  etm;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Two-bit batch; then a drain with a shadow swap (no bubble).
    tbl.push_back('{16'h0000, 1'b1, 32'd0,   1'b1, 1'b0, 16'd0, 32'd0,   1'b0});
    tbl.push_back('{16'h0081, 1'b1, 32'd100, 1'b0, 1'b1, 16'd0, 32'd100, 1'b1});
    tbl.push_back('{16'h0000, 1'b1, 32'd101, 1'b0, 1'b1, 16'd7, 32'd100, 1'b1});
    tbl.push_back('{16'h0000, 1'b1, 32'd102, 1'b0, 1'b0, 16'd0, 32'd0,   1'b0});
    tbl.push_back('{16'h0000, 1'b1, 32'd0,   1'b1, 1'b0, 16'd0, 32'd0,   1'b0});
    tbl.push_back('{16'h000F, 1'b1, 32'd10,  1'b0, 1'b1, 16'd0, 32'd10,  1'b1});
    tbl.push_back('{16'h0010, 1'b1, 32'd11,  1'b0, 1'b1, 16'd1, 32'd10,  1'b1});
    tbl.push_back('{16'h0000, 1'b1, 32'd12,  1'b0, 1'b1, 16'd2, 32'd10,  1'b1});
    tbl.push_back('{16'h0000, 1'b1, 32'd13,  1'b0, 1'b1, 16'd3, 32'd10,  1'b1});
    tbl.push_back('{16'h0000, 1'b1, 32'd14,  1'b0, 1'b1, 16'd4, 32'd11,  1'b1});
    tbl.push_back('{16'h0000, 1'b1, 32'd15,  1'b0, 1'b0, 16'd0, 32'd0,   1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].sp, tbl[i].rdy, tbl[i].t, tbl[i].rst);
      chk($sformatf("tbl%0d_valid", i), 32'(v0), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_busy", i), 32'(b0), 32'(tbl[i].eb));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_nid", i), 32'(n0), 32'(tbl[i].enid));
        chk($sformatf("tbl%0d_time", i), t0, tbl[i].etm);
      end
    end

    // ENGINE_ID=2 id offset and stall stability.
    cycle(16'h0000, 1'b0, 32'd0, 1'b1);
    cycle(16'h0008, 1'b0, 32'd50, 1'b0);
    chk("eng2_nid", 32'(n2), 32'd35);
    for (int i = 0; i < 5; i++) begin
      cycle(16'h0000, 1'b0, 32'(51 + i), 1'b0);
      chk("stall_valid", 32'(v2), 32'd1);
      chk("stall_nid", 32'(n2), 32'd35);
      chk("stall_time", t2, 32'd50);
    end
    cycle(16'h0000, 1'b1, 32'd60, 1'b0);
    chk("release_valid", 32'(v2), 32'd0);

    // Double spike into the shadow: one pulse, one event.
    cycle(16'h0000, 1'b0, 32'd0, 1'b1);
    cycle(16'h0001, 1'b0, 32'd20, 1'b0);
    cycle(16'h0020, 1'b0, 32'd21, 1'b0);
    chk("ovf_first", 32'(o0), 32'd0);
    cycle(16'h0020, 1'b0, 32'd22, 1'b0);
    chk("ovf_pulse", 32'(o0), 32'd1);
`ifdef SNE_SPIKE_ENC_OVF_CNT_EN
    chk("ovf_cnt1", 32'(c0), 32'd1);
`else
    chk("ovf_cnt1", 32'(c0), 32'd0);
`endif
    cycle(16'h0000, 1'b0, 32'd23, 1'b0);
    chk("ovf_clear", 32'(o0), 32'd0);
    cycle(16'h0000, 1'b1, 32'd24, 1'b0);
    chk("swap_nid5", 32'(n0), 32'd5);
    chk("swap_time", t0, 32'd21);
    cycle(16'h0000, 1'b1, 32'd25, 1'b0);
    chk("single_nid5", 32'(v0), 32'd0);

    // Counter saturation.
    cycle(16'h0000, 1'b0, 32'd0, 1'b1);
    cycle(16'h0001, 1'b0, 32'd30, 1'b0);
    cycle(16'hFFFF, 1'b0, 32'd31, 1'b0);
    for (int i = 0; i < 4400; i++) cycle(16'hFFFF, 1'b0, 32'd32, 1'b0);
`ifdef SNE_SPIKE_ENC_OVF_CNT_EN
    chk("cnt_sat", 32'(c0), 32'h0000FFFF);
`else
    chk("cnt_sat", 32'(c0), 32'h0);
`endif
    for (int i = 0; i < 20; i++) cycle(16'h0000, 1'b1, 32'd40, 1'b0);
    chk("sat_drained", 32'(b0), 32'd0);

    // Reset mid-drain discards everything.
    cycle(16'h0000, 1'b0, 32'd0, 1'b1);
    cycle(16'h0007, 1'b0, 32'd70, 1'b0);
    cycle(16'h0000, 1'b0, 32'd71, 1'b1);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_busy", 32'(b0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(16'h0000, 1'b1, 32'(72 + i), 1'b0);
      chk("rst_no_evt", 32'(v0), 32'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] sp;
      sp = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      if ($urandom_range(0, 7) == 0) sp = 16'(1 << $urandom_range(0, 15));
      cycle(sp, 1'($urandom_range(0, 3) != 0), 32'(1000 + i),
            1'($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
